// File: rtl/rst_seq_pkg.sv
// Shared types and widths for the staged reset sequencer.
//   state_t : FSM encoding, also exported on state_o for debug/LED use
//   STAGE_W : width of the stage index, sized for the largest supported N_CH
package rst_seq_pkg;

  localparam int unsigned N_CH_MAX = 8;
  localparam int unsigned STAGE_W  = $clog2(N_CH_MAX + 1);
  localparam int unsigned STATE_W  = 3;

  typedef enum logic [STATE_W-1:0] {
    WAIT_LOCK = 3'd0,
    PWR_WAIT  = 3'd1,
    STAGE     = 3'd2,
    WAIT_DONE = 3'd3,
    RUN       = 3'd4
  } state_t;

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchroniser for a bus of independent asynchronous flags.
//   clk   : destination clock
//   rst_n : asynchronous active-low reset, clears both stages
//   d     : asynchronous input flags
//   q     : synchronised flags, two clk edges behind d
module sync_2ff #(
  parameter int unsigned WIDTH = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] meta_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta_q <= '0;
      q      <= '0;
    end else begin
      meta_q <= d;
      q      <= meta_q;
    end
  end

endmodule

// File: rtl/rst_seq_ctrl.sv
// Power-up reset sequencer: filters PLL lock, waits a power-on delay, releases
// N_CH active-low reset domains in ascending order, then monitors N_DONE
// init-done flags with an optional sticky timeout. Lock loss or sw_rst re-arms.
//   clk          : system clock
//   sys_rst_n    : asynchronous active-low reset
//   pll_lock     : PLL lock, synchronous to clk
//   sw_rst       : soft re-arm request
//   done_i       : asynchronous init-done flags
//   rstn_o       : staged active-low resets, bit 0 released first
//   init_done    : all done flags high and all resets released
//   init_timeout : sticky, DONE_TO expired while waiting for done flags
//   state_o      : current FSM state encoding
module rst_seq_ctrl
  import rst_seq_pkg::*;
#(
  parameter int unsigned N_CH      = 2,
  parameter int unsigned N_DONE    = 2,
  parameter int unsigned CNT_W     = 24,
  parameter int unsigned LOCK_FILT = 16,
  parameter int unsigned PWR_DLY   = 16777215,
  parameter int unsigned STAGE_DLY = 1024,
  parameter int unsigned DONE_TO   = 16777215
) (
  input  logic              clk,
  input  logic              sys_rst_n,
  input  logic              pll_lock,
  input  logic              sw_rst,
  input  logic [N_DONE-1:0] done_i,
  output logic [N_CH-1:0]   rstn_o,
  output logic              init_done,
  output logic              init_timeout,
  output logic [2:0]        state_o
);

  state_t               state_q, state_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [STAGE_W-1:0]   stage_q, stage_d;
  logic [N_CH-1:0]      rstn_q, rstn_d;
  logic                 done_q, done_d;
  logic                 to_q, to_d;
  logic [N_DONE-1:0]    done_sync;

  logic all_done;
  logic rearm;
  logic lock_tc;
  logic pwr_tc;
  logic stage_tc;
  logic last_stage;
  logic to_tc;
  logic cnt_sat;

  sync_2ff #(
    .WIDTH (N_DONE)
  ) u_done_sync (
    .clk   (clk),
    .rst_n (sys_rst_n),
    .d     (done_i),
    .q     (done_sync)
  );

  // Terminal counts: the counter holds the number of edges already spent in
  // the state, so the transition edge is the one where it reads DLY-1.
  assign all_done   = &done_sync;
  assign rearm      = sw_rst || (!pll_lock && (state_q != WAIT_LOCK));
  assign lock_tc    = (cnt_q == CNT_W'(LOCK_FILT - 1));
  assign pwr_tc     = (cnt_q == CNT_W'(PWR_DLY - 1));
  assign stage_tc   = (cnt_q == CNT_W'(STAGE_DLY - 1));
  assign to_tc      = (DONE_TO != 0) && (cnt_q == CNT_W'(DONE_TO - 1));
  assign cnt_sat    = (cnt_q == CNT_W'(DONE_TO));
  assign last_stage = (stage_q == STAGE_W'(N_CH - 1));

  // State and datapath registers
  always_ff @(posedge clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state_q <= WAIT_LOCK;
      cnt_q   <= '0;
      stage_q <= '0;
      rstn_q  <= '0;
      done_q  <= 1'b0;
      to_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      stage_q <= stage_d;
      rstn_q  <= rstn_d;
      done_q  <= done_d;
      to_q    <= to_d;
    end
  end

  // Next-state logic; re-arm overrides everything else
  always_comb begin
    state_d = state_q;
    if (rearm) begin
      state_d = WAIT_LOCK;
    end else begin
      case (state_q)
        WAIT_LOCK: if (pll_lock && lock_tc) state_d = PWR_WAIT;
        PWR_WAIT:  if (pwr_tc) state_d = (N_CH == 1) ? WAIT_DONE : STAGE;
        STAGE:     if (stage_tc && last_stage) state_d = WAIT_DONE;
        WAIT_DONE: if (all_done) state_d = RUN;
        RUN:       if (!all_done) state_d = WAIT_DONE;
        default:   state_d = WAIT_LOCK;
      endcase
    end
  end

  // Counter, stage index and registered output next values
  always_comb begin
    cnt_d   = cnt_q;
    stage_d = stage_q;
    rstn_d  = rstn_q;
    to_d    = to_q;
    done_d  = 1'b0;
    if (rearm) begin
      cnt_d   = '0;
      stage_d = '0;
      rstn_d  = '0;
      to_d    = 1'b0;
    end else begin
      case (state_q)
        WAIT_LOCK: begin
          if (!pll_lock || lock_tc) cnt_d = '0;
          else                      cnt_d = cnt_q + CNT_W'(1);
        end
        PWR_WAIT: begin
          if (pwr_tc) begin
            rstn_d[0] = 1'b1;
            stage_d   = STAGE_W'(1);
            cnt_d     = '0;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
        STAGE: begin
          if (stage_tc) begin
            for (int unsigned i = 0; i < N_CH; i++) begin
              if (STAGE_W'(i) == stage_q) rstn_d[i] = 1'b1;
            end
            stage_d = stage_q + STAGE_W'(1);
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
        WAIT_DONE: begin
          // Done takes precedence over a coincident timeout
          if (all_done) begin
            cnt_d = '0;
          end else begin
            if (!cnt_sat) cnt_d = cnt_q + CNT_W'(1);
            if (to_tc)    to_d  = 1'b1;
          end
        end
        RUN: begin
          cnt_d  = '0;
          done_d = all_done;
        end
        default: cnt_d = '0;
      endcase
    end
  end

  assign rstn_o       = rstn_q;
  assign init_done    = done_q;
  assign init_timeout = to_q;
  assign state_o      = state_q;

endmodule

// File: doc/rst_seq_ctrl.md
Name: rst_seq_ctrl

Overview:
Parametrised power-up reset sequencer and init monitor, the successor to the single-counter reset-release block. It filters PLL lock, waits a power-on delay, then releases N_CH active-low reset domains in staged order. It then aggregates N_DONE asynchronous init-done flags into init_done, with a timeout flag. Loss of lock or a soft-reset request re-arms the whole sequence. Sits at top level between the PLL/system reset and all downstream domains (DDR, HDMI, pipeline).

Parameters:
N_CH, 2, number of staged reset outputs (1..8)
N_DONE, 2, number of init-done inputs (1..8)
CNT_W, 24, width of the shared delay/timeout counter
LOCK_FILT, 16, consecutive cycles pll_lock must be high before sequencing (1..2^CNT_W-1)
PWR_DLY, 16777215, cycles from lock-qualified to rstn_o[0] release (1..2^CNT_W-1)
STAGE_DLY, 1024, cycles between successive rstn_o releases (1..2^CNT_W-1)
DONE_TO, 16777215, cycles allowed in WAIT_DONE before init_timeout; 0 disables the timeout

Ports:
clk  in  1  system clock (single domain)
sys_rst_n  in  1  asynchronous active-low reset
pll_lock  in  1  PLL lock indicator, synchronous to clk
sw_rst  in  1  soft re-arm request, single-cycle pulse or level
done_i  in  N_DONE  init-done flags; asynchronous, synchronised internally
rstn_o  out  N_CH  staged active-low resets; bit 0 releases first
init_done  out  1  all done_i high and all resets released
init_timeout  out  1  sticky: DONE_TO expired before all done_i high
state_o  out  3  current FSM state encoding, for debug/LED

Behaviour:
- One clock, clk. Reset is asynchronous and active-low on sys_rst_n. All outputs are registered.
- Values under sys_rst_n=0: rstn_o=0, init_done=0, init_timeout=0, state=WAIT_LOCK, counter=0, stage index=0, sync flops=0.
- States:
  - WAIT_LOCK: counter counts cycles with pll_lock=1 and clears to 0 when pll_lock=0. On the edge where the count equals LOCK_FILT: go to PWR_WAIT, clear the counter.
  - PWR_WAIT: counter increments. On reaching PWR_DLY: set rstn_o[0]=1, stage=1, clear the counter. If N_CH=1 go to WAIT_DONE, else go to STAGE.
  - STAGE: counter increments. On reaching STAGE_DLY: set rstn_o[stage]=1, stage+1, clear the counter. After bit N_CH-1 is set, go to WAIT_DONE.
  - WAIT_DONE: counter increments, saturating at DONE_TO. If all synced done bits are 1: go to RUN. Else if DONE_TO!=0 and counter reaches DONE_TO: set init_timeout=1 and remain in WAIT_DONE.
  - RUN: init_done=1. If any synced done bit drops: init_done=0 on the next edge, go to WAIT_DONE, clear the counter. init_timeout is not cleared.
- Timing, with edge 1 being the first edge sampling pll_lock=1:
  - rstn_o[0] rises at edge LOCK_FILT+PWR_DLY.
  - rstn_o[k] rises STAGE_DLY*k edges after rstn_o[0].
  - Release order is strictly ascending.
- done_i goes through a 2-flop synchroniser per bit. init_done rises 3 edges after the last done_i rises, provided the FSM is already in WAIT_DONE.
- Re-arm: pll_lock=0 in any state other than WAIT_LOCK, or sw_rst=1 in any state, causes the following on the next edge:
  - rstn_o=0, init_done=0, init_timeout=0;
  - counter=0, stage=0, state=WAIT_LOCK.
- Priority: re-arm > done/timeout > counter progress. A simultaneous lock loss and counter terminal count resolves as re-arm.
- sw_rst held high keeps the block in WAIT_LOCK with the counter at 0. The lock filter restarts after sw_rst deasserts.
- Counter arithmetic: unsigned, CNT_W bits. Terminal compare uses ==. The counter never wraps.
- sys_rst_n asserted mid-sequence returns all state to reset values immediately (asynchronously).

Decomposition:
- Package rst_seq_pkg:
  - state enum WAIT_LOCK=0, PWR_WAIT=1, STAGE=2, WAIT_DONE=3, RUN=4 (3-bit, drives state_o);
  - localparam width for the stage index, $clog2(N_CH+1).
- Sub-module sync_2ff, parametrised width, async active-low reset to 0, used for done_i.
- FSM, counter and stage register stay in rst_seq_ctrl.

Test Plan:
Bench parameters: N_CH=3, N_DONE=2, LOCK_FILT=4, PWR_DLY=10, STAGE_DLY=3, DONE_TO=50.
- Nominal: pll_lock=1 from edge 1, done_i=11 at edge 30 -> rstn_o bits rise at edges 14/17/20, init_done=1 at edge 33, init_timeout=0.
- Lock glitch: pll_lock high 3 cycles, low 1, then high -> no release until 4 consecutive high cycles; rstn_o[0] rises 14 edges after the second rise.
- Lock loss after rstn_o=011 -> next edge rstn_o=000, state_o=0; re-lock repeats the full 14/17/20 timing.
- Timeout: done_i=01 held -> init_timeout=1 at edge 70 (50 edges after entering WAIT_DONE at edge 20); done_i=11 later -> init_done=1, init_timeout stays 1.
- In RUN, drop done_i[1] -> init_done=0 within 3 edges, state_o=3; reassert -> init_done=1 again.
- sw_rst pulse in RUN -> rstn_o=000, init_done=0, init_timeout=0 next edge; sequence restarts with nominal timing.
